// File: rtl/onehot_select_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : onehot_select_reg_if
// Description : Channel-select bus between function units and the registered
//               one-hot selector. master = producer/consumer side,
//               slave = selector block.
// Revision    : 1.0 - initial release
// ============================================================================
interface onehot_select_reg_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 16
);
    localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       hotselect;
    logic                      sel_valid;
    logic                      sel_ready;
    logic [WIDTH-1:0]          muxout;
    logic                      out_valid;
    logic                      out_ready;
    logic [IDXW-1:0]           last_index;
    logic                      sel_err;
    logic                      err_clear;
    logic [7:0]                err_count;

    modport master (
        output in_data, hotselect, sel_valid, out_ready, err_clear,
        input  sel_ready, muxout, out_valid, last_index, sel_err, err_count
    );

    modport slave (
        input  in_data, hotselect, sel_valid, out_ready, err_clear,
        output sel_ready, muxout, out_valid, last_index, sel_err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/onehot_select_reg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_select_reg
// Description : Registered CHANNELS-way one-hot word selector with a
//               valid/ready output register, illegal-select detection and a
//               saturating illegal-select counter.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_select_reg #(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 16,
    parameter int STICKY_ERR = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    onehot_select_reg_if.slave   bus
);
    // Interface instance must be built with the same WIDTH/CHANNELS.
    localparam int       IDXW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam bit [7:0] c_CNT_MAX = 8'hFF;

    logic [WIDTH-1:0] r_muxout;
    logic             r_out_valid;
    logic [IDXW-1:0]  r_last_index;
    logic             r_sel_err;
    logic [7:0]       r_err_count;

    logic [WIDTH-1:0] w_data;
    logic [IDXW-1:0]  w_idx;
    logic             w_any;
    logic             w_multi;
    logic             w_legal;
    logic             w_sel_ready;
    logic             w_accept;
    logic             w_bad_accept;

    // Decode the select: OR-merge selected words, track "any" and "more than one".
    always_comb begin
        w_data  = '0;
        w_idx   = '0;
        w_any   = 1'b0;
        w_multi = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.hotselect[k]) begin
                w_multi = w_multi | w_any;
                w_any   = 1'b1;
                w_idx   = IDXW'(k);
                w_data  = w_data | bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_legal      = w_any & ~w_multi;
    // Ready depends only on the output register state, never on sel_valid.
    assign w_sel_ready  = ~r_out_valid | bus.out_ready;
    assign w_accept     = bus.sel_valid & w_sel_ready;
    assign w_bad_accept = w_accept & ~w_legal;

    // Output register: load on legal accept, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_muxout     <= '0;
            r_out_valid  <= 1'b0;
            r_last_index <= '0;
        end else if (w_accept && w_legal) begin
            r_muxout     <= w_data;
            r_last_index <= w_idx;
            r_out_valid  <= 1'b1;
        end else if (bus.out_ready) begin
            // Illegal accept or idle: a consumed result leaves the register.
            r_out_valid  <= 1'b0;
        end
    end

    // Saturating illegal-select counter; a new error outranks a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_bad_accept) begin
            if (bus.err_clear) begin
                r_err_count <= 8'd1;
            end else if (r_err_count != c_CNT_MAX) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end else if (bus.err_clear) begin
            r_err_count <= '0;
        end
    end

    generate
        if (STICKY_ERR != 0) begin : g_sticky_err
            // Error flag latches until cleared; a coincident error wins.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sel_err <= 1'b0;
                end else if (w_bad_accept) begin
                    r_sel_err <= 1'b1;
                end else if (bus.err_clear) begin
                    r_sel_err <= 1'b0;
                end
            end
        end else begin : g_pulse_err
            // Error flag is a single-cycle pulse following each illegal accept.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sel_err <= 1'b0;
                end else begin
                    r_sel_err <= w_bad_accept;
                end
            end
        end
    endgenerate

    assign bus.sel_ready  = w_sel_ready;
    assign bus.muxout     = r_muxout;
    assign bus.out_valid  = r_out_valid;
    assign bus.last_index = r_last_index;
    assign bus.sel_err    = r_sel_err;
    assign bus.err_count  = r_err_count;
endmodule
`default_nettype wire

// File: doc/onehot_select_reg.md
Name: onehot_select_reg

Overview:
- Parametrised, registered successor to the team's combinational 16-way one-hot result selector.
- Picks one of CHANNELS operand/result words using a one-hot select.
- Registers the chosen word behind a valid/ready handshake.
- Detects and counts illegal selects (zero-hot or multi-hot) instead of silently holding stale data.
- Sits between the calculator's function units and the output/middleware interface.

Parameters:
- WIDTH, 32, data word width in bits.
- CHANNELS, 16, number of input channels; legal range 2..64.
- STICKY_ERR, 1, 1 = sel_err stays set until err_clear; 0 = sel_err is a one-cycle pulse.
- Local IDXW = max(1, clog2(CHANNELS)); index width.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_data, input, CHANNELS*WIDTH, flattened channel words; channel k at bits [k*WIDTH +: WIDTH].
- hotselect, input, CHANNELS, one-hot channel select; bit k selects channel k.
- sel_valid, input, 1, hotselect/in_data presented this cycle.
- sel_ready, output, 1, block can accept this cycle.
- muxout, output, WIDTH, registered selected word.
- out_valid, output, 1, muxout holds an unconsumed result.
- out_ready, input, 1, downstream consumes muxout when out_valid is high.
- last_index, output, IDXW, binary index of the channel captured in muxout.
- sel_err, output, 1, illegal-select flag.
- err_clear, input, 1, clears sel_err and err_count.
- err_count, output, 8, saturating count of illegal selects.

Behaviour:
- Reset (rst high at a clock edge): muxout=0, out_valid=0, last_index=0, sel_err=0, err_count=0. rst overrides every other input, including mid-handshake; any pending output is discarded.
- sel_ready = !out_valid || out_ready. It is combinational, with no dependency on sel_valid.
- accept = sel_valid && sel_ready.
- Legal select means exactly one bit of hotselect is set (popcount == 1).
- Accept with legal select, next edge:
  - muxout <= channel word k.
  - last_index <= k.
  - out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Accept with illegal select (0 or more than 1 bit set):
  - The transaction is consumed and dropped.
  - muxout and last_index hold.
  - out_valid <= 0 if out_ready was high (prior result consumed), otherwise it holds.
  - sel_err <= 1.
  - err_count increments, saturating at 255.
- No accept and out_valid && out_ready: out_valid <= 0; muxout holds its value.
- No accept and out_valid && !out_ready: all outputs hold. This is backpressure: the result is never overwritten while unconsumed.
- Simultaneous consume and legal accept: out_valid stays 1 and muxout updates, giving full throughput of one result per cycle.
- sel_valid low: hotselect and in_data are ignored, and no error is raised for an invalid select pattern.
- STICKY_ERR=1:
  - sel_err stays set until a cycle with err_clear high.
  - err_clear and a new illegal accept in the same cycle: sel_err=1 and err_count=1, so the error wins over the clear.
- STICKY_ERR=0:
  - sel_err is high exactly one cycle after each illegal accept.
  - err_clear affects err_count only.
- err_clear with no illegal accept: err_count <= 0.
- Data path: pure bit selection, no arithmetic. muxout is never X after reset.

Test Plan (CHANNELS=16, WIDTH=32, channel k word = 32'hA000_0000+k):
- Reset: hold rst 2 cycles with sel_valid=1, hotselect=16'h0004 -> muxout=0, out_valid=0, sel_err=0, err_count=0 throughout reset and on the first edge after it.
- Streaming: out_ready=1; present hotselect 16'h0001, 16'h0200, 16'h8000 on 3 consecutive cycles -> muxout=A000_0000, A000_0009, A000_000F on the following 3 cycles; last_index=0,9,15; out_valid continuously 1.
- Backpressure: capture 16'h0020 (muxout=A000_0005), then out_ready=0 for 4 cycles while sel_valid=1 with hotselect=16'h0040 -> sel_ready=0 and muxout stays A000_0005. Raise out_ready -> next cycle muxout=A000_0006.
- Illegal selects: present 16'h0000, then 16'h0011, after a legal 16'h0008 result -> muxout holds A000_0003, sel_err=1, err_count=2, no new out_valid beat.
- Clear vs. error collision (STICKY_ERR=1): err_clear=1 in the same cycle as an accept of 16'h0300 -> sel_err=1, err_count=1.
- Saturation and reset mid-operation: issue 300 illegal accepts -> err_count=255. Then assert rst while out_valid=1 and out_ready=0 -> all outputs 0 next edge. Repeat the illegal accept with STICKY_ERR=0 -> sel_err high for exactly 1 cycle.
